psk_frame_scheduler: RTL and testbench

Frame sequencer between the payload FIFO and the PSK modulator. Presents a first-word-fall-through byte source (sample / empty / read) that the modulator consumes. Per frame, emits a fixed preamble, a sync word, N payload bytes pulled from the upstream FIFO, an optional CRC-8 byte, then a quiet gap. Software or the host interface starts each frame with a one-cycle pulse and monitors busy, done and underrun.

---
 rtl/psk_frame_scheduler_pkg.sv | 30 +++
 rtl/psk_frame_scheduler_if.sv | 12 +
 rtl/psk_frame_scheduler_crc8.sv | 14 +
 rtl/psk_frame_scheduler.sv | 147 ++++++++++++++
 tb/tb_psk_frame_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psk_frame_scheduler_pkg.sv
// Shared types and constants for the PSK frame scheduler.
// PSK_SCHED_CRC8_EN: leave undefined by default; define it to append a CRC-8 byte to each frame.
package psk_frame_scheduler_pkg;

    localparam int BYTE_W = 8;

    // MSB-first CRC-8, no reflection, no final XOR
    localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SYNC     = 3'd2,
        S_PAYLOAD  = 3'd3,
`ifdef PSK_SCHED_CRC8_EN
        S_CRC      = 3'd4,
`endif
        S_GAP      = 3'd5
    } state_t;

    function automatic logic [BYTE_W-1:0] crc8_byte(input logic [BYTE_W-1:0] crc,
                                                    input logic [BYTE_W-1:0] data);
        logic [BYTE_W-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < BYTE_W; i++)
            c = c[BYTE_W-1] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/psk_frame_scheduler_if.sv
// First-word-fall-through byte stream: the master offers data/empty, the slave pops with read.
interface psk_frame_scheduler_if;
    import psk_frame_scheduler_pkg::*;

    logic [BYTE_W-1:0] data;
    logic              empty;
    logic              read;

    modport master (output data, output empty, input read);
    modport slave  (input data, input empty, output read);

endinterface

// File: rtl/psk_frame_scheduler_crc8.sv
// One-byte combinational CRC-8 update; only present when PSK_SCHED_CRC8_EN is defined.
`ifdef PSK_SCHED_CRC8_EN
module crc8_update
    import psk_frame_scheduler_pkg::*;
(
    input  logic [BYTE_W-1:0] crc_in,
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] crc_out
);

    assign crc_out = crc8_byte(crc_in, data);

endmodule
`endif

// File: rtl/psk_frame_scheduler.sv
// Frame sequencer: preamble, sync, payload from upstream FIFO, optional CRC-8, then a quiet gap.
// PSK_SCHED_CRC8_EN (default undefined) adds the CRC state and byte.
module psk_frame_scheduler
    import psk_frame_scheduler_pkg::*;
#(
    parameter int              PREAMBLE_LEN  = 4,
    parameter logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [BYTE_W-1:0] SYNC_WORD     = 8'h7E,
    parameter int              GAP_CYCLES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_W-1:0]     payload_len,
    psk_frame_scheduler_if.slave  up,
    psk_frame_scheduler_if.master mod,
    output logic                  busy,
    output logic                  done,
    output logic                  underrun
);

    localparam int                GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [BYTE_W-1:0] PRE_LAST = BYTE_W'(PREAMBLE_LEN - 1);
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t            state, state_nx;
    logic [BYTE_W-1:0] cnt;
    logic [BYTE_W-1:0] len;
    logic [GW-1:0]     gap_cnt;
    logic              take;

    // a read against an empty offer is not a consumption
    assign take = mod.read & ~mod.empty;

`ifdef PSK_SCHED_CRC8_EN
    logic [BYTE_W-1:0] crc_q, crc_nx;
    localparam state_t S_TAIL = S_CRC;

    crc8_update u_crc (
        .crc_in  (crc_q),
        .data    (up.data),
        .crc_out (crc_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc_q <= '0;
        else if (state == S_IDLE && start)
            crc_q <= '0;
        else if (state == S_PAYLOAD && take)
            crc_q <= crc_nx;
    end
`else
    localparam state_t S_TAIL = S_GAP;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mod.data  = '0;
        mod.empty = 1'b1;
        up.read   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                mod.data  = PREAMBLE_BYTE;
                mod.empty = 1'b0;
                if (mod.read && cnt == PRE_LAST) state_nx = S_SYNC;
            end
            S_SYNC: begin
                mod.data  = SYNC_WORD;
                mod.empty = 1'b0;
                if (mod.read) state_nx = (len == '0) ? S_TAIL : S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // FIFO head passes straight through; the pop is the modulator's read
                mod.data  = up.data;
                mod.empty = up.empty;
                up.read   = mod.read & ~up.empty;
                if (mod.read && !up.empty && cnt == len - 8'd1) state_nx = S_TAIL;
            end
`ifdef PSK_SCHED_CRC8_EN
            S_CRC: begin
                mod.data  = crc_q;
                mod.empty = 1'b0;
                if (mod.read) state_nx = S_GAP;
            end
`endif
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            len      <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len      <= payload_len;
                        cnt      <= '0;
                        gap_cnt  <= '0;
                        underrun <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_PREAMBLE: begin
                    if (take) cnt <= cnt + 8'd1;
                end
                S_SYNC: begin
                    if (take) cnt <= '0;
                end
                S_PAYLOAD: begin
                    // sticky until the next accepted start; the frame just waits for data
                    if (up.empty) underrun <= 1'b1;
                    if (take) cnt <= cnt + 8'd1;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psk_frame_scheduler.sv
// Scoreboard bench: tests push expected bytes, negedge monitors model FIFO + modulator and pop/compare.
module tb_psk_frame_scheduler;

    localparam int SYM = 16;
    localparam int G0  = 16;
    localparam int G1  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start1 = 1'b0;
    logic [7:0] plen = 8'h00, plen1 = 8'h00;
    logic       busy, done, underrun, busy1, done1, underrun1;

    psk_frame_scheduler_if up(), mod(), up1(), mod1();

    psk_frame_scheduler #(.GAP_CYCLES(G0)) dut (
        .clk(clk), .rst(rst), .start(start), .payload_len(plen),
        .up(up), .mod(mod), .busy(busy), .done(done), .underrun(underrun)
    );

    psk_frame_scheduler #(.GAP_CYCLES(G1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .payload_len(plen1),
        .up(up1), .mod(mod1), .busy(busy1), .done(done1), .underrun(underrun1)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // main DUT: FIFO model + 16-cycle-symbol modulator + scoreboard
    logic [7:0] exp_q[$], fifo_q[$];
    logic       up_pop = 1'b0;
    int         cyc = 0, last_cap = 0, cap_cnt = 0, done_cnt = 0;
    bit         frame_active = 0, busy_drop = 0, up_read_seen = 0;

    always @(posedge clk) up_pop <= up.read;

    initial begin
        int hold;
        hold = 0;
        mod.read = 1'b0;
        up.data  = 8'h00;
        up.empty = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (up_pop) up_read_seen = 1;
            if (up_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
            up.data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
            up.empty = (fifo_q.size() == 0);
            #1;
            if (done) begin
                check("done_gap_cycles", cyc - last_cap, G0 + 1);
                done_cnt++;
                frame_active = 0;
            end
            if (frame_active && !busy) busy_drop = 1;
            if (rst) begin
                mod.read = 1'b0;
                hold = 0;
            end else if (mod.read) begin
                mod.read = 1'b0;
                hold = SYM - 2;
            end else if (hold > 0) begin
                hold--;
            end else if (!mod.empty) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_byte: got %0h, required no byte", mod.data);
                end else begin
                    check("stream_byte", mod.data, exp_q.pop_front());
                end
                mod.read = 1'b1;
                last_cap = cyc;
                cap_cnt++;
            end
        end
    end

    // GAP_CYCLES=1 DUT: consumer reads every third cycle
    logic [7:0] exp1_q[$], fifo1_q[$];
    logic       up1_pop = 1'b0;
    int         cyc1 = 0, last_cap1 = 0, done1_cnt = 0;

    always @(posedge clk) up1_pop <= up1.read;

    initial begin
        int hold;
        hold = 0;
        mod1.read = 1'b0;
        up1.data  = 8'h00;
        up1.empty = 1'b1;
        forever begin
            @(negedge clk);
            cyc1++;
            if (up1_pop && fifo1_q.size() > 0) void'(fifo1_q.pop_front());
            up1.data  = (fifo1_q.size() > 0) ? fifo1_q[0] : 8'h00;
            up1.empty = (fifo1_q.size() == 0);
            #1;
            if (done1) begin
                check("b2b_done_gap", cyc1 - last_cap1, G1 + 1);
                done1_cnt++;
            end
            if (rst) begin
                mod1.read = 1'b0;
                hold = 0;
            end else if (mod1.read) begin
                mod1.read = 1'b0;
                hold = 1;
            end else if (hold > 0) begin
                hold--;
            end else if (!mod1.empty) begin
                if (exp1_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b2b_extra_byte: got %0h, required no byte", mod1.data);
                end else begin
                    check("b2b_byte", mod1.data, exp1_q.pop_front());
                end
                mod1.read = 1'b1;
                last_cap1 = cyc1;
            end
        end
    end

    task automatic push_header(input bit second);
        for (int i = 0; i < 4; i++) begin
            if (second) exp1_q.push_back(8'h55); else exp_q.push_back(8'h55);
        end
        if (second) exp1_q.push_back(8'h7E); else exp_q.push_back(8'h7E);
    endtask

    task automatic do_start(input logic [7:0] len);
        @(negedge clk); #2;
        plen = len;
        start = 1'b1;
        busy_drop = 0;
        up_read_seen = 0;
        @(posedge clk); #1;
        start = 1'b0;
        frame_active = 1;
        check("start_latency_mod_empty", mod.empty, 1'b0);
        check("busy_after_start", busy, 1'b1);
        check("underrun_cleared_on_start", underrun, 1'b0);
    endtask

    task automatic wait_caps(input int target, input string name);
        int n;
        n = 0;
        while (cap_cnt < target && n < 2000) begin
            @(negedge clk); #2;
            n++;
        end
        if (cap_cnt < target) flag_fail(name);
    endtask

    task automatic wait_done(input int base, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge clk); #2;
            n++;
        end
        if (done_cnt == base) begin
            flag_fail(name);
            frame_active = 0;
        end
        check({name, "_busy_held"}, busy_drop, 1'b0);
        check({name, "_all_bytes_seen"}, exp_q.size(), 0);
    endtask

    task automatic wait_done1(input int target, input string name);
        int n;
        n = 0;
        while (done1_cnt < target && n < 500) begin
            @(negedge clk); #2;
            n++;
        end
        if (done1_cnt < target) flag_fail(name);
    endtask

    initial begin
        int base;
        // reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_mod_empty", mod.empty, 1'b1);
        check("rst_mod_sample", mod.data, 8'h00);
        check("rst_up_read", up.read, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // frame 1: 01,02,03 with a start pulse during PAYLOAD that must be ignored
        fifo_q = {8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB};
        push_header(0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
`ifdef PSK_SCHED_CRC8_EN
        exp_q.push_back(8'h48);
`endif
        base = done_cnt;
        do_start(8'd3);
        wait_caps(cap_cnt + 6, "reach_payload");
        @(negedge clk); #2;
        plen = 8'd9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_on_ignored_start", busy, 1'b1);
        wait_done(base, "frame1");
        check("frame1_no_underrun", underrun, 1'b0);

        // frame 2: start the cycle after done, payload AA,BB left in the FIFO
        push_header(0);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
`ifdef PSK_SCHED_CRC8_EN
        exp_q.push_back(8'hB2);
`endif
        base = done_cnt;
        do_start(8'd2);
        wait_done(base, "frame2");

        // zero-length frame
        push_header(0);
`ifdef PSK_SCHED_CRC8_EN
        exp_q.push_back(8'h00);
`endif
        base = done_cnt;
        do_start(8'd0);
        wait_done(base, "zero_len");
        check("zero_len_no_up_read", up_read_seen, 1'b0);

        // underrun: FIFO runs dry after byte 01
        fifo_q.push_back(8'h01);
        push_header(0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
`ifdef PSK_SCHED_CRC8_EN
        exp_q.push_back(8'h48);
`endif
        base = done_cnt;
        do_start(8'd3);
        wait_caps(cap_cnt + 6, "reach_payload_ur");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            if (i % 4 == 3) check("stall_mod_empty", mod.empty, 1'b1);
        end
        check("underrun_set", underrun, 1'b1);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03);
        wait_done(base, "underrun_frame");
        check("underrun_sticky", underrun, 1'b1);

        // async reset mid-PAYLOAD while the modulator is reading
        fifo_q = {8'h01, 8'h02, 8'h03};
        push_header(0);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        base = done_cnt;
        do_start(8'd3);
        wait_caps(cap_cnt + 7, "reach_byte2");
        check("up_read_before_rst", up.read, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_mod_empty", mod.empty, 1'b1);
        check("async_rst_up_read", up.read, 1'b0);
        exp_q.delete();
        fifo_q.delete();
        frame_active = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check("post_rst_idle_busy", busy, 1'b0);
        check("post_rst_idle_mod_empty", mod.empty, 1'b1);
        check("post_rst_no_done", done_cnt, base);

        // GAP_CYCLES=1 back-to-back frames
        fifo1_q = {8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB};
        push_header(1);
        exp1_q.push_back(8'h01); exp1_q.push_back(8'h02); exp1_q.push_back(8'h03);
`ifdef PSK_SCHED_CRC8_EN
        exp1_q.push_back(8'h48);
`endif
        push_header(1);
        exp1_q.push_back(8'hAA); exp1_q.push_back(8'hBB);
`ifdef PSK_SCHED_CRC8_EN
        exp1_q.push_back(8'hB2);
`endif
        @(negedge clk); #2;
        plen1 = 8'd3;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_done1(1, "b2b_frame1");
        @(negedge clk); #2;
        plen1 = 8'd2;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("b2b_second_start_busy", busy1, 1'b1);
        wait_done1(2, "b2b_frame2");
        check("b2b_done_count", done1_cnt, 2);
        check("b2b_all_bytes_seen", exp1_q.size(), 0);
        check("b2b_fifo_drained", fifo1_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
